// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller: state encoding and channel geometry.
package mux_scan_pkg;

  localparam int def_width  = 4;
  localparam int def_swidth = 4;
  localparam int nch        = 2 ** def_swidth;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mux_if.sv
// Behavioural 16:1 mux scanned by mux_scan_ctrl; purely combinational.
module mux_if import mux_scan_pkg::*; #(
  parameter int width  = def_width,
  parameter int swidth = def_swidth
) (
  input  logic [2**swidth-1:0][width-1:0] din,
  input  logic [swidth-1:0]               sel,
  output logic [width-1:0]                mux_o
);

  assign mux_o = din[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller: walks the enabled mux channels, captures each word and hands it
// downstream over valid/ready, tagged with its channel number.
module mux_scan_ctrl import mux_scan_pkg::*; #(
  parameter int width  = def_width,
  parameter int swidth = def_swidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cont,
  input  logic [2**swidth-1:0] mask,
  output logic [swidth-1:0]    sel,
  input  logic [width-1:0]     mux_o,
  output logic [width-1:0]     o_data,
  output logic [swidth-1:0]    o_ch,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 busy,
  output logic                 done
);

  state_e               state;
  logic [swidth-1:0]    ptr;
  logic [2**swidth-1:0] mask_q;
  logic                 cont_q;
  logic                 pass_end;

  // The last channel of a single pass ends the scan instead of wrapping.
  assign pass_end = (&ptr) && !cont_q;

  assign sel  = ptr;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: every register here, including the sampled mask/cont, takes its reset
  // value and is updated with <= so all of them see the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state  <= SCAN;
            ptr    <= '0;
            mask_q <= mask;
            cont_q <= cont;
          end
        end

        SCAN: begin
          if (stop) begin
            state   <= IDLE;
            ptr     <= '0;
            o_valid <= 1'b0;
          end else if (mask_q[ptr]) begin
            o_data  <= mux_o;
            o_ch    <= ptr;
            o_valid <= 1'b1;
            state   <= HOLD;
          end else if (pass_end) begin
            state <= DONE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + swidth'(1);
          end
        end

        HOLD: begin
          // stop wins over a simultaneous handshake; the pending word is dropped.
          if (stop) begin
            state   <= IDLE;
            ptr     <= '0;
            o_valid <= 1'b0;
          end else if (o_ready) begin
            o_valid <= 1'b0;
            if (pass_end) begin
              state <= DONE;
              ptr   <= '0;
            end else begin
              state <= SCAN;
              ptr   <= ptr + swidth'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
          ptr   <= '0;
        end

        default: begin
          state <= IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl driving mux_if: a distance-based reference model
// plus directed scenarios with literal expectations and randomized scans.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int W  = 4;
  localparam int SW = 4;
  localparam int N  = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                cont = 1'b0;
  logic                o_ready = 1'b0;
  logic [N-1:0]        mask = '0;
  logic [N-1:0][W-1:0] din = '0;
  logic [SW-1:0]       sel, o_ch;
  logic [W-1:0]        mux_o, o_data;
  logic                o_valid, busy, done;

  always #5 clk = ~clk;

  mux_if #(.width(W), .swidth(SW)) u_mux (
    .din(din), .sel(sel), .mux_o(mux_o)
  );

  mux_scan_ctrl #(.width(W), .swidth(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont), .mask(mask),
    .sel(sel), .mux_o(mux_o), .o_data(o_data), .o_ch(o_ch), .o_valid(o_valid),
    .o_ready(o_ready), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instead of walking a pointer it computes, at each decision point,
  // how many cycles remain until the next enabled channel (or the end of the pass).
  bit         m_busy, m_valid, m_done, m_cont, m_tdone;
  bit [N-1:0] m_mask;
  int         m_sel, m_ch, m_data, m_from, m_elapsed, m_cnt, m_target;
  int         cyc = 0;
  int         st_cyc = 0;

  function automatic void plan(input int from);
    int  lim;
    bit  found;
    lim       = m_cont ? N - 1 : N - 1 - from;
    found     = 1'b0;
    m_from    = from;
    m_elapsed = 0;
    m_sel     = from;
    m_cnt     = -1;
    m_tdone   = 1'b0;
    for (int d = 0; d <= lim; d++) begin
      if (!found && m_mask[(from + d) % N]) begin
        found    = 1'b1;
        m_cnt    = d + 1;
        m_target = (from + d) % N;
      end
    end
    if (!found && !m_cont) begin
      m_cnt   = N - from;
      m_tdone = 1'b1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_cont = 0; m_tdone = 0; m_mask = '0;
      m_sel = 0; m_ch = 0; m_data = 0; m_cnt = -1; m_from = 0; m_elapsed = 0;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy = 1; m_mask = mask; m_cont = cont; st_cyc = cyc;
          plan(0);
        end
      end else if (stop) begin
        m_busy = 0; m_valid = 0; m_done = 0; m_sel = 0;
      end else if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (m_valid) begin
        if (o_ready) begin
          m_valid = 0;
          if (m_ch == N - 1 && !m_cont) begin
            m_done = 1; m_sel = 0;
          end else begin
            plan((m_ch + 1) % N);
          end
        end
      end else begin
        m_elapsed++;
        m_sel = (m_from + m_elapsed) % N;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            if (m_tdone) begin
              m_done = 1; m_sel = 0;
            end else begin
              m_valid = 1; m_ch = m_target; m_data = din[m_target]; m_sel = m_target;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison and transaction log, sampled mid-cycle.
  int obs_ch[$];
  int obs_data[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int hs_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("sel", sel, m_sel);
      check("o_valid", o_valid, m_valid);
      check("o_ch", o_ch, m_ch);
      check("o_data", o_data, m_data);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      if (o_valid && o_ready) begin
        obs_ch.push_back(int'(o_ch));
        obs_data.push_back(int'(o_data));
        hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Background drivers run at posedge+2 so directed tasks (posedge+3) always win.
  bit rdy_auto = 0, rdy_rand = 0, scramble = 0;
  always @(posedge clk) begin
    #2;
    if (rdy_auto) o_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
    if (scramble) begin
      mask = N'($urandom);
      cont = 1'($urandom % 2);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic launch(input logic [N-1:0] m, input bit c);
    obs_ch.delete();
    obs_data.delete();
    done_cnt = 0;
    mask  = m;
    cont  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == 0) check({name, " timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!o_valid && n < budget) begin
      tick();
      n++;
    end
    if (!o_valid) check({name, " timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [N-1:0] m;
    bit c;
    logic [W-1:0] d0;

    #1;
    check("reset sel", sel, 0);
    check("reset o_data", o_data, 0);
    check("reset o_ch", o_ch, 0);
    check("reset o_valid", o_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Full pass, ik=k: 16 SCAN+HOLD pairs occupy cycles 1..32, done in cycle 33.
    for (int k = 0; k < N; k++) din[k] = W'(k);
    rdy_auto = 1; rdy_rand = 0;
    launch(16'hFFFF, 1'b0);
    wait_done(100, "full done");
    check("busy after done", busy, 0);
    check("full words", obs_ch.size(), 16);
    for (int k = 0; k < N && k < obs_ch.size(); k++) begin
      check($sformatf("full ch[%0d]", k), obs_ch[k], k);
      check($sformatf("full data[%0d]", k), obs_data[k], k);
    end
    check("full done cycle", done_cyc - st_cyc + 1, 33);
    check("full done after last hs", done_cyc, hs_cyc + 1);
    tick(2);

    // Sparse mask: 12 skipped channels x1 + 4 enabled x2 = 20 cycles, done in cycle 21.
    launch(16'h8421, 1'b0);
    wait_done(100, "sparse done");
    check("sparse words", obs_ch.size(), 4);
    for (int k = 0; k < 4 && k < obs_ch.size(); k++)
      check($sformatf("sparse ch[%0d]", k), obs_ch[k], 5 * k);
    check("sparse done cycle", done_cyc - st_cyc + 1, 21);
    tick(2);

    // Backpressure on channel 0 for 5 cycles.
    for (int k = 0; k < N; k++) din[k] = W'($urandom);
    rdy_auto = 0; o_ready = 1'b0;
    launch(16'h0003, 1'b0);
    wait_valid(10, "bp valid");
    d0 = din[0];
    for (int i = 0; i < 5; i++) begin
      check("bp o_valid", o_valid, 1);
      check("bp o_ch", o_ch, 0);
      check("bp o_data", o_data, d0);
      check("bp sel", sel, 0);
      tick();
    end
    o_ready = 1'b1;
    wait_done(50, "bp done");
    check("bp words", obs_ch.size(), 2);
    if (obs_ch.size() == 2) begin
      check("bp ch0", obs_ch[0], 0);
      check("bp data0", obs_data[0], din[0]);
      check("bp ch1", obs_ch[1], 1);
      check("bp data1", obs_data[1], din[1]);
    end
    tick(2);

    // Continuous wrap with mask 8001, then stop during HOLD on channel 15.
    rdy_auto = 1; rdy_rand = 0;
    launch(16'h8001, 1'b1);
    n = 0;
    while (obs_ch.size() < 6 && n < 300) begin tick(); n++; end
    check("cont words", obs_ch.size() >= 6, 1);
    for (int k = 0; k < 6 && k < obs_ch.size(); k++)
      check($sformatf("cont ch[%0d]", k), obs_ch[k], (k % 2 == 0) ? 0 : 15);
    n = 0;
    while (!(o_valid && o_ch == 4'd15) && n < 50) begin tick(); n++; end
    check("cont hold on 15", o_valid && o_ch == 4'd15, 1);
    c = 1'b0;
    n = obs_ch.size();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop o_valid", o_valid, 0);
    check("stop busy", busy, 0);
    check("stop no hs", obs_ch.size(), n + 1);
    check("cont no done", done_cnt, 0);
    tick(2);

    // Empty mask single pass: 16 SCAN cycles, done in cycle 17, no words.
    launch(16'h0000, 1'b0);
    wait_done(50, "empty done");
    check("empty words", obs_ch.size(), 0);
    check("empty done cycle", done_cyc - st_cyc + 1, 17);
    tick(2);

    // Empty mask continuous: silent until stop.
    launch(16'h0000, 1'b1);
    tick(40);
    check("empty cont busy", busy, 1);
    check("empty cont words", obs_ch.size(), 0);
    check("empty cont done", done_cnt, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("empty cont stopped", busy, 0);
    tick(2);

    // start while busy is ignored; start+stop in IDLE stays idle.
    rdy_rand = 1;
    launch(16'hFFFF, 1'b0);
    tick(5);
    mask = 16'h0001; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300, "busy start done");
    check("busy start words", obs_ch.size(), 16);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start+stop idle", busy, 0);
    tick();
    check("start+stop idle 2", busy, 0);

    // Randomized scans with changing mask/cont during the scan and random backpressure.
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < N; k++) din[k] = W'($urandom);
      m = N'($urandom);
      if (it % 3 == 0) m = m & N'($urandom) & N'($urandom);
      c = ($urandom % 4 == 0);
      launch(m, c);
      scramble = 1;
      if (c || ($urandom % 4 == 0)) begin
        tick($urandom_range(5, 60));
        stop = 1'b1; tick(); stop = 1'b0;
        check("rand stop busy", busy, 0);
      end else begin
        wait_done(400, "rand done");
        check("rand words", obs_ch.size(), $countones(m));
      end
      scramble = 0;
      tick(2);
    end

    // Asynchronous reset mid-HOLD.
    rdy_auto = 0; o_ready = 1'b0;
    din[0] = 4'hA;
    launch(16'hFFFF, 1'b0);
    wait_valid(10, "rst valid");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst sel", sel, 0);
    check("arst o_data", o_data, 0);
    check("arst o_ch", o_ch, 0);
    check("arst o_valid", o_valid, 0);
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post rst idle", busy, 0);
      check("post rst valid", o_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
